// File: rtl/ru_wb_arbiter.sv
// ru_wb_arbiter: shares the register unit's single write port between the ALU (A)
// and load-unit (B) writeback paths, keeps a per-register busy scoreboard, and
// raises stall to the issue stage on RAW/WAW hazards. Reset is synchronous, active-low.
// Optional feature macro: RU_WB_BYPASS_EN. When defined, a register written in the
// current cycle does not stall its readers, and fwdRs1/fwdRs2 with fwdSel1/fwdSel2
// carry the write data straight to the datapath.
module ru_wb_arbiter #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wbValidA,
  input  logic [AW-1:0]    wbRdA,
  input  logic [DW-1:0]    wbDataA,
  output logic             wbReadyA,
  input  logic             wbValidB,
  input  logic [AW-1:0]    wbRdB,
  input  logic [DW-1:0]    wbDataB,
  output logic             wbReadyB,
  input  logic             issueVld,
  input  logic [AW-1:0]    issueRd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             stall,
  output logic             ruWr,
  output logic [AW-1:0]    rd,
  output logic [DW-1:0]    dataWR_Ru,
`ifdef RU_WB_BYPASS_EN
  output logic [DW-1:0]    fwdRs1,
  output logic [DW-1:0]    fwdRs2,
  output logic             fwdSel1,
  output logic             fwdSel2,
`endif
  output logic [CNT_W-1:0] conflictCnt
);

  // rr_ptr = 0 prefers A on a conflict, 1 prefers B.
  logic             rr_ptr;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  set_vec;
  logic [NREG-1:0]  clr_vec;
  logic [CNT_W-1:0] conflict_q;
  logic             both;
  logic             grant_a;
  logic             grant_b;
  logic             hit_rs1;
  logic             hit_rs2;
  logic             hit_waw;

  assign both        = wbValidA & wbValidB;
  assign conflictCnt = conflict_q;

  // Pick one winner per cycle; a lone requester always wins, round robin breaks ties.
  always_comb begin
    grant_a = wbValidA & (~wbValidB | ~rr_ptr);
    grant_b = wbValidB & ~grant_a;
  end

  // Drive the RU write port from the granted source; idle port reads as all zeros.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves it
    // unassigned; a missing default here would infer a latch.
    wbReadyA  = 1'b0;
    wbReadyB  = 1'b0;
    ruWr      = 1'b0;
    rd        = '0;
    dataWR_Ru = '0;
    if (grant_a) begin
      wbReadyA  = 1'b1;
      rd        = wbRdA;
      dataWR_Ru = wbDataA;
      ruWr      = (wbRdA != '0);
    end else if (grant_b) begin
      wbReadyB  = 1'b1;
      rd        = wbRdB;
      dataWR_Ru = wbDataB;
      ruWr      = (wbRdB != '0);
    end
  end

  // Hazard detection: RAW on either source, WAW on the destination.
  always_comb begin
    hit_rs1 = (rs1 != '0) & busy[rs1];
    hit_rs2 = (rs2 != '0) & busy[rs2];
    hit_waw = (issueRd != '0) & busy[issueRd];
`ifdef RU_WB_BYPASS_EN
    // The value being written this cycle is forwarded, so readers need not wait.
    if (ruWr && (rs1 == rd)) hit_rs1 = 1'b0;
    if (ruWr && (rs2 == rd)) hit_rs2 = 1'b0;
`endif
    stall = hit_rs1 | hit_rs2 | hit_waw;
  end

`ifdef RU_WB_BYPASS_EN
  // Forward the in-flight write to a matching source operand.
  always_comb begin
    fwdSel1 = ruWr & (rs1 == rd);
    fwdSel2 = ruWr & (rs2 == rd);
    fwdRs1  = fwdSel1 ? dataWR_Ru : '0;
    fwdRs2  = fwdSel2 ? dataWR_Ru : '0;
  end
`endif

  // One-hot set/clear requests for the scoreboard this cycle.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issueVld && !stall && (issueRd != '0)) set_vec[issueRd] = 1'b1;
    if (ruWr) clr_vec[rd] = 1'b1;
  end

  // Scoreboard update: a simultaneous set beats a clear; x0 never becomes busy.
  always_ff @(posedge clk) begin
    // NOTE: busy is a small flop vector, not a RAM, so it is reset like any
    // other register and the issue stage sees a clean scoreboard after reset.
    if (!rst_n) begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      busy <= '0;
    end else begin
      busy <= ((busy & ~clr_vec) | set_vec) & ~{{(NREG-1){1'b0}}, 1'b1};
    end
  end

  // Round-robin pointer: after a conflict the loser becomes preferred.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (both) begin
      rr_ptr <= grant_a;
    end
  end

  // Saturating count of cycles where both sources requested.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else if (both && (conflict_q != {CNT_W{1'b1}})) begin
      conflict_q <= conflict_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ru_wb_arbiter.sv
// Testbench for ru_wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
// Honors RU_WB_BYPASS_EN when defined for the build.
module tb_ru_wb_arbiter;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wbValidA, wbValidB, wbReadyA, wbReadyB;
  logic [AW-1:0]    wbRdA, wbRdB, issueRd, rs1, rs2, rd;
  logic [DW-1:0]    wbDataA, wbDataB, dataWR_Ru;
  logic             issueVld, stall, ruWr;
  logic [CNT_W-1:0] conflictCnt;
`ifdef RU_WB_BYPASS_EN
  logic [DW-1:0]    fwdRs1, fwdRs2;
  logic             fwdSel1, fwdSel2;
`endif

  ru_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbValidA(wbValidA), .wbRdA(wbRdA), .wbDataA(wbDataA), .wbReadyA(wbReadyA),
    .wbValidB(wbValidB), .wbRdB(wbRdB), .wbDataB(wbDataB), .wbReadyB(wbReadyB),
    .issueVld(issueVld), .issueRd(issueRd), .rs1(rs1), .rs2(rs2), .stall(stall),
    .ruWr(ruWr), .rd(rd), .dataWR_Ru(dataWR_Ru),
`ifdef RU_WB_BYPASS_EN
    .fwdRs1(fwdRs1), .fwdRs2(fwdRs2), .fwdSel1(fwdSel1), .fwdSel2(fwdSel2),
`endif
    .conflictCnt(conflictCnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  bit          m_busy [NREG];
  bit          m_b_turn;      // 1 when B wins the next tie
  int          m_conf;
  logic [DW-1:0] ru_mem [NREG]; // register file image built from the write port
  bit          checking = 1'b0;

  // Per-step samples and model grant decisions, used by directed tests.
  logic          s_ready_a, s_ready_b, s_ruwr, s_stall;
  logic [CNT_W-1:0] s_conf;
  logic [DW-1:0] s_fwd1;
  bit            e_ga, e_gb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_stall(bit wr, logic [AW-1:0] grd);
    bit s1, s2, sw;
    s1 = (rs1 != 0) && m_busy[rs1];
    s2 = (rs2 != 0) && m_busy[rs2];
    sw = (issueRd != 0) && m_busy[issueRd];
`ifdef RU_WB_BYPASS_EN
    if (wr && rs1 == grd) s1 = 1'b0;
    if (wr && rs2 == grd) s2 = 1'b0;
`endif
    return s1 || s2 || sw;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    m_b_turn = 1'b0;
    m_conf   = 0;
  endtask

  // One clock cycle: compare at negedge, then advance the model at posedge.
  task automatic step();
    bit both, wr, est;
    logic [AW-1:0] grd;
    logic [DW-1:0] gdat;
    @(negedge clk);
    both = wbValidA && wbValidB;
    e_ga = wbValidA && !(wbValidB && m_b_turn);
    e_gb = wbValidB && !e_ga;
    grd  = e_ga ? wbRdA : (e_gb ? wbRdB : '0);
    gdat = e_ga ? wbDataA : (e_gb ? wbDataB : '0);
    wr   = (e_ga || e_gb) && (grd != 0);
    est  = model_stall(wr, grd);
    s_ready_a = wbReadyA; s_ready_b = wbReadyB; s_ruwr = ruWr;
    s_stall = stall; s_conf = conflictCnt; s_fwd1 = '0;
`ifdef RU_WB_BYPASS_EN
    s_fwd1 = fwdRs1;
`endif
    if (checking) begin
      check("wbReadyA", 64'(wbReadyA), 64'(e_ga));
      check("wbReadyB", 64'(wbReadyB), 64'(e_gb));
      check("ruWr", 64'(ruWr), 64'(wr));
      check("rd", 64'(rd), 64'(grd));
      check("dataWR_Ru", 64'(dataWR_Ru), 64'(gdat));
      check("stall", 64'(stall), 64'(est));
      check("conflictCnt", 64'(conflictCnt), 64'(m_conf));
`ifdef RU_WB_BYPASS_EN
      check("fwdRs1", 64'(fwdRs1), 64'((wr && rs1 == grd) ? gdat : '0));
      check("fwdRs2", 64'(fwdRs2), 64'((wr && rs2 == grd) ? gdat : '0));
      check("fwdSel1", 64'(fwdSel1), 64'(wr && rs1 == grd));
`endif
    end
    @(posedge clk);
    if (ruWr && rd != 0) ru_mem[rd] = dataWR_Ru;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (both) begin
        m_b_turn = e_ga;
        if (m_conf < CMAX) m_conf++;
      end
      if (wr) m_busy[grd] = 1'b0;
      if (issueVld && !est && issueRd != 0) m_busy[issueRd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wbValidA = 0; wbRdA = '0; wbDataA = '0;
    wbValidB = 0; wbRdB = '0; wbDataB = '0;
    issueVld = 0; issueRd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) ru_mem[r] = '0;
    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    step();           // DUT state unknown before the first reset edge
    checking = 1'b1;
    do_reset();

    // Reset then idle for 3 cycles.
    for (int c = 0; c < 3; c++) begin
      step();
      check("idle_ruWr", 64'(s_ruwr), 64'(0));
      check("idle_stall", 64'(s_stall), 64'(0));
      check("idle_conf", 64'(s_conf), 64'(0));
      check("idle_ready", 64'({s_ready_a, s_ready_b}), 64'(0));
    end

    // RAW on x5 resolved by an ALU write in cycle 4.
    issueVld = 1; issueRd = 5; rs1 = 0;
    step();
    issueRd = 0; rs1 = 5;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin wbValidA = 1; wbRdA = 5; wbDataA = 32'hDEAD_BEEF; end
      step();
`ifdef RU_WB_BYPASS_EN
      check("raw_stall", 64'(s_stall), 64'(c < 4));
      if (c == 4) check("raw_fwd", 64'(s_fwd1), 64'(32'hDEAD_BEEF));
`else
      check("raw_stall", 64'(s_stall), 64'(1));
`endif
    end
    wbValidA = 0;
    step();
    check("raw_release", 64'(s_stall), 64'(0));
    check("ru_x5", 64'(ru_mem[5]), 64'(32'hDEAD_BEEF));
    idle_inputs();

    // Conflicts: both valid for 4 cycles, winners alternate A,B,A,B.
    do_reset();
    wbValidA = 1; wbRdA = 1; wbDataA = 32'hA0;
    wbValidB = 1; wbRdB = 2; wbDataB = 32'hB0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("rr_grant_a", 64'(s_ready_a), 64'(c % 2 == 0));
      check("rr_grant_b", 64'(s_ready_b), 64'(c % 2 == 1));
      if (e_ga) begin wbRdA = AW'(3 + c); wbDataA = 32'hA1 + c; end
      if (e_gb) begin wbRdB = AW'(9 + c); wbDataB = 32'hB1 + c; end
    end
    wbValidA = 0; wbValidB = 0;
    step();
    check("conf_after4", 64'(s_conf), 64'(4));

    // B write to x0 completes without touching the RU.
    wbValidB = 1; wbRdB = 0; wbDataB = 32'h1234;
    step();
    check("x0_readyB", 64'(s_ready_b), 64'(1));
    check("x0_ruWr", 64'(s_ruwr), 64'(0));
    check("x0_value", 64'(ru_mem[0]), 64'(0));
    wbValidB = 0;

    // Issue rd=7 while x7 is written: set wins, rs2=7 then stalls.
    wbValidA = 1; wbRdA = 7; wbDataA = 32'h77;
    issueVld = 1; issueRd = 7;
    step();
    check("set_wins_nostall", 64'(s_stall), 64'(0));
    wbValidA = 0; issueRd = 0; rs2 = 7;
    step();
    check("set_wins_stall", 64'(s_stall), 64'(1));
    idle_inputs();
    wbValidA = 1; wbRdA = 7; wbDataA = 32'h78;
    step();
    idle_inputs();

    // Counter saturation: 2^CNT_W+2 conflict cycles.
    do_reset();
    wbValidA = 1; wbRdA = 1; wbValidB = 1; wbRdB = 2;
    for (int c = 0; c < CMAX + 3; c++) step();
    idle_inputs();
    step();
    check("conf_saturated", 64'(s_conf), 64'(CMAX));
    do_reset();
    step();
    check("conf_cleared", 64'(s_conf), 64'(0));

    // Random traffic; losers hold their request until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!wbValidA && $urandom_range(0, 2) != 0) begin
        wbValidA = 1; wbRdA = AW'($urandom_range(0, 7)); wbDataA = $urandom;
      end
      if (!wbValidB && $urandom_range(0, 2) != 0) begin
        wbValidB = 1; wbRdB = AW'($urandom_range(0, 7)); wbDataB = $urandom;
      end
      issueVld = ($urandom_range(0, 1) == 1);
      issueRd  = AW'($urandom_range(0, 7));
      rs1      = AW'($urandom_range(0, 7));
      rs2      = AW'($urandom_range(0, 7));
      rst_n    = ($urandom_range(0, 499) != 0);
      step();
      if (e_ga || !rst_n) wbValidA = 0;
      if (e_gb || !rst_n) wbValidB = 0;
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
